i2c_txn_sequencer: RTL
======================

# i2c_txn_sequencer

Command sequencer sitting directly upstream of the I2C master in the `clk_400` domain. It accepts one complete transaction per command: 7-bit target address, direction, and 1..MAX_BYTES data bytes. It drives the master's start/rw/address/data/next_byte inputs, collects read bytes and the ACK outcome, and returns a single response word to the host. It owns all byte counting and error classification, so the host never handles bus-level timing.

## Interface
- `MAX_BYTES`, 4: maximum bytes per transaction; `LW` = $clog2(MAX_BYTES+1).
- `TIMEOUT_CYC`, 1024: watchdog limit in `clk_400` cycles from launch to `m_done`.
- `clk_400`  in  1  single clock (400 kHz); all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  7  target address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_len`  in  LW  byte count; legal range 1..MAX_BYTES.
- `cmd_wdata`  in  8*MAX_BYTES  write bytes; byte 0 in [7:0].
- `rsp_valid`  out  1  response valid, held until accepted.
- `rsp_ready`  in  1  host accepts response.
- `rsp_status`  out  2  00 OK, 01 address NACK, 10 data NACK, 11 abort.
- `rsp_count`  out  LW  bytes completed.
- `rsp_rdata`  out  8*MAX_BYTES  read bytes; byte 0 in [7:0]; unread bytes are 0.
- `m_start_txn`, `m_rw`  out  1  to master.
- `m_sub_addr`  out  7  to master.
- `m_data_in`  out  8  current write byte.
- `m_next_byte`  out  1  another byte follows the current one.
- `m_data_out`  in  8  read byte from master.
- `m_data_ready`, `m_busy`, `m_done`, `m_ack_error`  in  1  master status.
- `m_byte_done`  in  1  one-cycle pulse from master at the end of each write-byte ACK slot.

## Operation
- States: IDLE, LAUNCH, XFER, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch the command, clear byte index `idx` and `rsp_rdata`, and check length:
  - `cmd_len` = 0 or > MAX_BYTES: go to RESP with status 11, count 0. No bus activity.
  - Otherwise go to LAUNCH.
- LAUNCH: hold `m_start_txn`=1 until `m_busy`=1 is sampled. Then drop it and go to XFER.
- Throughout LAUNCH and XFER:
  - `m_sub_addr`/`m_rw` are driven from the latched command.
  - `m_data_in` = wdata byte[`idx`].
  - `m_next_byte` = (`idx`+1 < len).
- XFER, write: each `m_byte_done` pulse increments `idx`, saturating at len.
- XFER, read: on each rising edge of `m_data_ready` (previous-cycle register), store `m_data_out` into byte[`idx`] and increment `idx`.
- XFER, completion: on a rising edge of `m_done`, go to RESP with `rsp_count` = `idx`. Status:
  - `m_ack_error`=1 and `idx`=0: status 01.
  - `m_ack_error`=1 and `idx`>0: status 10.
  - `m_ack_error`=0: status 00.
- Same-cycle `m_data_ready` edge and `m_done` edge: capture the byte first; the count includes it.
- RESP: `rsp_valid`=1 and response fields are stable. Return to IDLE on `rsp_ready`.

## Timing
- Reset values:
  - state IDLE; `cmd_ready`=1 (combinational from state).
  - `rsp_valid`=0, `rsp_status`=0, `rsp_count`=0, `rsp_rdata`=0.
  - `m_start_txn`=0, `m_rw`=0, `m_sub_addr`=0, `m_data_in`=0, `m_next_byte`=0.
- `rst` mid-transaction: all of the above are restored on the next edge. The master is reset separately.
- Command accept to `m_start_txn` high: 1 cycle.
- Illegal length to `rsp_valid`: 1 cycle.
- `m_done` edge to `rsp_valid`: 1 cycle.
- `rsp_ready` while `rsp_valid` is high: `rsp_valid` drops next cycle and `cmd_ready` rises the same cycle.
- `rsp_ready` asserted before `rsp_valid`: ignored.
- A new command cannot be accepted in the cycle the response is consumed.

## Configuration
- `I2C_SEQ_TIMEOUT_EN` defined: a watchdog counter starts on entry to LAUNCH.
  - Reaching TIMEOUT_CYC before an `m_done` edge: drop `m_start_txn`, go to RESP with status 11 and count = `idx`.
- Undefined: no counter is built; status 11 occurs only for illegal length; a stuck master holds the sequencer in XFER.

## Test plan
- Write addr 0x50, len 2, data {0x5A,0xA5}:
  - `m_next_byte`=1 then 0; two `m_byte_done` pulses, then `m_done` with no ack error.
  - Expect status 00, count 2.
- Read addr 0x68, len 3, master returns 0x11, 0x22, 0x33:
  - Expect `rsp_rdata`[23:0]=0x332211, count 3, status 00.
- `m_ack_error`=1 with `m_done` and no bytes completed: expect status 01, count 0.
- Write len 3 with ack error after byte 1: expect status 10, count 1.
- `cmd_len`=0, and separately `cmd_len`=5: expect `rsp_valid` one cycle after accept, status 11, `m_start_txn` never asserted.
- With `I2C_SEQ_TIMEOUT_EN`, master never asserts `m_done`:
  - Expect status 11 after 1024 cycles.
  - Assert `rst` mid-XFER in a separate run: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/i2c_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : i2c_txn_sequencer_if
// Host command/response channel plus I2C-master control/status signals.
// Revision  : 1.0
// ============================================================================
interface i2c_txn_sequencer_if #(
  parameter int MAX_BYTES = 4
);
  localparam int LW = $clog2(MAX_BYTES + 1);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [6:0]             cmd_addr;
  logic                   cmd_rw;
  logic [LW-1:0]          cmd_len;
  logic [8*MAX_BYTES-1:0] cmd_wdata;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_status;
  logic [LW-1:0]          rsp_count;
  logic [8*MAX_BYTES-1:0] rsp_rdata;

  logic                   m_start_txn;
  logic                   m_rw;
  logic [6:0]             m_sub_addr;
  logic [7:0]             m_data_in;
  logic                   m_next_byte;
  logic [7:0]             m_data_out;
  logic                   m_data_ready;
  logic                   m_busy;
  logic                   m_done;
  logic                   m_ack_error;
  logic                   m_byte_done;

  // master: the sequencer's view; slave: the host and I2C master around it
  modport master (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_len, cmd_wdata, rsp_ready,
           m_data_out, m_data_ready, m_busy, m_done, m_ack_error, m_byte_done,
    output cmd_ready, rsp_valid, rsp_status, rsp_count, rsp_rdata,
           m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_rw, cmd_len, cmd_wdata, rsp_ready,
           m_data_out, m_data_ready, m_busy, m_done, m_ack_error, m_byte_done,
    input  cmd_ready, rsp_valid, rsp_status, rsp_count, rsp_rdata,
           m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_sequencer
// One-command-per-transaction sequencer in front of an I2C master; defining
// I2C_SEQ_TIMEOUT_EN adds a launch-to-done watchdog.
// Revision : 1.0
// ============================================================================
module i2c_txn_sequencer #(
  parameter int MAX_BYTES   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_400,
  input  logic                rst,
  i2c_txn_sequencer_if.master bus
);
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int DW = 8 * MAX_BYTES;
  localparam logic [LW-1:0] c_max_len = LW'(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_XFER   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [LW-1:0]   len_q, len_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            start_q, start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [LW-1:0]   rsp_count_q, rsp_count_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            dr_prev_q;
  logic            done_prev_q;

  logic            w_active;
  logic            w_dr_rise;
  logic            w_done_rise;
  logic            w_next;
  logic [7:0]      w_cur_byte;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int c_tw = $clog2(TIMEOUT_CYC + 1);
  logic [c_tw-1:0] wdog_q, wdog_d;
`else
  localparam int c_unused_timeout = TIMEOUT_CYC;
`endif

  assign w_active    = (state_q == S_LAUNCH) || (state_q == S_XFER);
  assign w_dr_rise   = bus.m_data_ready & ~dr_prev_q;
  assign w_done_rise = bus.m_done & ~done_prev_q;
  assign w_next      = ({1'b0, idx_q} + 1'b1) < {1'b0, len_q};

  // idx may legitimately reach MAX_BYTES, which selects no byte
  always_comb begin
    w_cur_byte = 8'd0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == LW'(i)) w_cur_byte = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    start_d      = start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_count_d  = rsp_count_q;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    wdog_d       = wdog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          rw_d        = bus.cmd_rw;
          len_d       = bus.cmd_len;
          wdata_d     = bus.cmd_wdata;
          idx_d       = '0;
          rsp_rdata_d = '0;
          if ((bus.cmd_len == '0) || (bus.cmd_len > c_max_len)) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = 2'b11;
            rsp_count_d  = '0;
          end else begin
            state_d = S_LAUNCH;
            start_d = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end
        end
      end

      S_LAUNCH: begin
        if (bus.m_busy) begin
          start_d = 1'b0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (!rw_q) begin
          if (bus.m_byte_done && (idx_q < len_q)) idx_d = idx_q + 1'b1;
        end else if (w_dr_rise && (idx_q < len_q)) begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (idx_q == LW'(i)) rsp_rdata_d[8*i +: 8] = bus.m_data_out;
          end
          idx_d = idx_q + 1'b1;
        end
        // a byte landing on the same edge as done is already in idx_d
        if (w_done_rise) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_count_d = idx_d;
          if (bus.m_ack_error) rsp_status_d = (idx_d == '0) ? 2'b01 : 2'b10;
          else                 rsp_status_d = 2'b00;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef I2C_SEQ_TIMEOUT_EN
    if (w_active) begin
      wdog_d = wdog_q + 1'b1;
      if ((wdog_q == c_tw'(TIMEOUT_CYC - 1)) &&
          !((state_q == S_XFER) && w_done_rise)) begin
        state_d      = S_RESP;
        start_d      = 1'b0;
        rsp_valid_d  = 1'b1;
        rsp_status_d = 2'b11;
        rsp_count_d  = idx_d;
      end
    end
`endif
  end

  always_ff @(posedge clk_400) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      len_q        <= '0;
      wdata_q      <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_count_q  <= '0;
      rsp_rdata_q  <= '0;
      dr_prev_q    <= 1'b0;
      done_prev_q  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_count_q  <= rsp_count_d;
      rsp_rdata_q  <= rsp_rdata_d;
      dr_prev_q    <= bus.m_data_ready;
      done_prev_q  <= bus.m_done;
`ifdef I2C_SEQ_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_count   = rsp_count_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.m_start_txn = start_q;
  assign bus.m_rw        = w_active & rw_q;
  assign bus.m_sub_addr  = w_active ? addr_q : 7'd0;
  assign bus.m_data_in   = w_active ? w_cur_byte : 8'd0;
  assign bus.m_next_byte = w_active & w_next;
endmodule
`default_nettype wire
